// File: rtl/axis_uart_tx.sv
// Buffered AXI-Stream to UART (8N1) transmitter: a small FIFO feeds a serializer
// that can append a 0x0A frame after every byte stored with tlast set.
module axis_uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 16_000_000,
  parameter int unsigned BAUD_RATE   = 57600,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned APPEND_NL   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tdata,
  input  logic       i_tlast,
  input  logic       i_tvalid,
  output logic       o_tready,
  output logic       o_uart_tx,
  output logic       o_busy
);

  localparam int unsigned DIV    = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [7:0]  NL     = 8'h0A;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [8:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [8:0]        head;

  state_t            state;
  state_t            state_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_cnt_d;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_idx_d;
  logic [7:0]        shreg;
  logic [7:0]        shreg_d;
  logic              nl_pend;
  logic              nl_pend_d;
  logic              tx_d;
  logic              busy_d;
  logic              bit_end;
  logic              load;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign o_tready = i_rst_n && !full;
  assign push     = i_tvalid && o_tready;
  assign head     = mem[rd_ptr];

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // FIFO storage: {tlast, tdata}
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_tlast, i_tdata};
  end

  // Serializer state register; line and busy are registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      nl_pend   <= 1'b0;
      o_uart_tx <= 1'b1;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_d;
      baud_cnt  <= baud_cnt_d;
      bit_idx   <= bit_idx_d;
      shreg     <= shreg_d;
      nl_pend   <= nl_pend_d;
      o_uart_tx <= tx_d;
      o_busy    <= busy_d;
    end
  end

  // Next-state logic; IDLE and the last STOP cycle share the frame selection
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shreg_d    = shreg;
    nl_pend_d  = nl_pend;
    tx_d       = o_uart_tx;
    pop        = 1'b0;
    load       = 1'b0;
    busy_d     = 1'b0;
    bit_end    = (baud_cnt == BAUD_W'(DIV - 1));

    case (state)
      IDLE: begin
        tx_d = 1'b1;
        load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          tx_d       = shreg[0];
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = {1'b0, shreg[7:1]};
            tx_d      = shreg[1];
          end
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          tx_d       = 1'b1;
          state_d    = IDLE;
          load       = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A pending newline has priority over the next queued byte
    if (load) begin
      if (nl_pend) begin
        shreg_d    = NL;
        nl_pend_d  = 1'b0;
        state_d    = START;
        tx_d       = 1'b0;
        baud_cnt_d = '0;
      end else if (!empty) begin
        pop        = 1'b1;
        shreg_d    = head[7:0];
        nl_pend_d  = (APPEND_NL != 0) && head[8];
        state_d    = START;
        tx_d       = 1'b0;
        baud_cnt_d = '0;
      end
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: two instances (no newline / depth 16, newline / depth 4),
// checked against a line-level waveform model and a sampling UART receiver model.
module tb_axis_uart_tx;

  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk;
  logic       rst_n;
  logic [7:0] tdata;
  logic       tlast;
  logic       tvalid;
  logic       sel;
  logic       tx0, busy0, rdy0;
  logic       tx1, busy1, rdy1;
  logic       tx_s, busy_s, rdy_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cnt = 0;
  int frame_err = 0;
  int busy_total = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  axis_uart_tx #(.CLK_FREQ_HZ(40), .BAUD_RATE(10), .FIFO_DEPTH(16), .APPEND_NL(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast),
    .i_tvalid(tvalid & ~sel), .o_tready(rdy0), .o_uart_tx(tx0), .o_busy(busy0));

  axis_uart_tx #(.CLK_FREQ_HZ(40), .BAUD_RATE(10), .FIFO_DEPTH(4), .APPEND_NL(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast),
    .i_tvalid(tvalid & sel), .o_tready(rdy1), .o_uart_tx(tx1), .o_busy(busy1));

  assign tx_s   = sel ? tx1 : tx0;
  assign busy_s = sel ? busy1 : busy0;
  assign rdy_s  = sel ? rdy1 : rdy0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_cnt = rst_cnt + 1;
  always @(negedge clk) if (busy_s === 1'b1) busy_total = busy_total + 1;

  // Receiver model: mid-bit sampling of the selected line; frames cut by reset are dropped
  always begin : rx_model
    logic [7:0] b;
    int t0, r0;
    bit ok;
    @(negedge clk);
    if (rst_n === 1'b1 && tx_s === 1'b0) begin
      t0 = cyc;
      r0 = rst_cnt;
      repeat (DIV / 2) @(negedge clk);
      ok = (tx_s === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = tx_s;
      end
      repeat (DIV) @(negedge clk);
      ok = ok && (tx_s === 1'b1);
      if (r0 == rst_cnt) begin
        if (!ok) frame_err = frame_err + 1;
        rx_q.push_back(b);
        rx_t.push_back(t0);
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one byte; returns just after the accepting edge with the number of stalled cycles
  task automatic push_byte(input logic [7:0] d, input logic l, output int stalls);
    bit r;
    stalls = 0;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    forever begin
      @(negedge clk);
      r = (rdy_s === 1'b1);
      @(posedge clk);
      if (r) break;
      stalls++;
      if (stalls >= 3000) begin
        chk("push_timeout", 0, 1);
        break;
      end
    end
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy_s === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk({name, "_idle_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic logic line_model(input int c, input int nfr, input logic [7:0] f0,
                                      input logic [7:0] f1);
    int k, f, p;
    logic [7:0] byt;
    if (c < 1 || c > nfr * FRAME) return 1'b1;
    k = c - 1;
    f = k / FRAME;
    p = (k % FRAME) / DIV;
    byt = (f == 0) ? f0 : f1;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return byt[p-1];
  endfunction

  typedef struct {
    logic       s;
    logic [7:0] d;
    logic       l;
    int         nfr;
    logic [7:0] f0;
    logic [7:0] f1;
  } vec_t;

  vec_t vt[5];

  initial begin : main
    int stalls, mism, first_low, busy_n, base, bbase, first_block;
    logic [7:0] expq[$];
    logic [7:0] fr[2];
    logic [7:0] d;
    logic l;
    logic pre;

    vt[0] = '{1'b0, 8'h55, 1'b0, 1, 8'h55, 8'h00};
    vt[1] = '{1'b1, 8'h41, 1'b1, 2, 8'h41, 8'h0A};
    vt[2] = '{1'b0, 8'h80, 1'b1, 1, 8'h80, 8'h00};
    vt[3] = '{1'b1, 8'h00, 1'b0, 1, 8'h00, 8'h00};
    vt[4] = '{1'b1, 8'hFF, 1'b1, 2, 8'hFF, 8'h0A};

    tdata = '0; tlast = 1'b0; tvalid = 1'b0; sel = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx0", int'(tx0), 1);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_rdy0", int'(rdy0), 0);
    chk("rst_tx1", int'(tx1), 1);
    chk("rst_rdy1", int'(rdy1), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-frame vectors: latency, bit-level waveform, busy length, decoded bytes
    for (int v = 0; v < 5; v++) begin
      sel = vt[v].s;
      @(posedge clk); #1;
      base = rx_q.size();
      push_byte(vt[v].d, vt[v].l, stalls);
      tvalid = 1'b0;
      mism = 0; first_low = -1; busy_n = 0;
      for (int c = 0; c < vt[v].nfr * FRAME + 4; c++) begin
        @(negedge clk);
        if (tx_s === 1'b0 && first_low < 0) first_low = c;
        if (tx_s !== line_model(c, vt[v].nfr, vt[v].f0, vt[v].f1)) mism++;
        if (busy_s === 1'b1) busy_n++;
      end
      chk($sformatf("v%0d_latency", v), first_low, 1);
      chk($sformatf("v%0d_wave_mism", v), mism, 0);
      chk($sformatf("v%0d_busy_cycles", v), busy_n, vt[v].nfr * FRAME);
      chk($sformatf("v%0d_rx_count", v), rx_q.size() - base, vt[v].nfr);
      fr[0] = vt[v].f0; fr[1] = vt[v].f1;
      for (int i = 0; i < vt[v].nfr && base + i < rx_q.size(); i++)
        chk($sformatf("v%0d_rx%0d", v, i), int'(rx_q[base+i]), int'(fr[i]));
      @(posedge clk); #1;
    end

    // Backpressure on the depth-4 instance
    sel = 1'b1;
    @(posedge clk); #1;
    base = rx_q.size(); bbase = busy_total; first_block = -1;
    for (int i = 0; i < 8; i++) begin
      push_byte(8'(i + 1), 1'b0, stalls);
      if (stalls > 0 && first_block < 0) begin
        first_block = i;
        chk("bp_stall_len", stalls, 37);
      end
    end
    tvalid = 1'b0;
    wait_idle("bp");
    chk("bp_first_block", first_block, 5);
    chk("bp_rx_count", rx_q.size() - base, 8);
    for (int i = 0; i < 8 && base + i < rx_q.size(); i++)
      chk($sformatf("bp_rx%0d", i), int'(rx_q[base+i]), i + 1);
    chk("bp_busy", busy_total - bbase, 8 * FRAME);

    // Back-to-back bytes: frames abut with no idle cycles
    base = rx_q.size(); bbase = busy_total;
    push_byte(8'h12, 1'b0, stalls);
    push_byte(8'h34, 1'b0, stalls);
    push_byte(8'h56, 1'b0, stalls);
    tvalid = 1'b0;
    wait_idle("b2b");
    chk("b2b_rx_count", rx_q.size() - base, 3);
    if (rx_q.size() - base == 3) begin
      chk("b2b_rx0", int'(rx_q[base]), 'h12);
      chk("b2b_rx1", int'(rx_q[base+1]), 'h34);
      chk("b2b_rx2", int'(rx_q[base+2]), 'h56);
      chk("b2b_gap01", rx_t[base+1] - rx_t[base], FRAME);
      chk("b2b_gap12", rx_t[base+2] - rx_t[base+1], FRAME);
    end
    chk("b2b_busy", busy_total - bbase, 3 * FRAME);

    // Reset in DATA bit 3 of 0xC3 with two bytes queued
    base = rx_q.size();
    push_byte(8'hC3, 1'b0, stalls);
    push_byte(8'h11, 1'b1, stalls);
    push_byte(8'h22, 1'b0, stalls);
    tvalid = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    pre = tx_s;
    chk("rstmid_pre_low", int'(pre), 0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx", int'(tx_s), 1);
    chk("rstmid_busy", int'(busy_s), 0);
    chk("rstmid_rdy", int'(rdy_s), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mism = 0; busy_n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx_s !== 1'b1) mism++;
      if (busy_s !== 1'b0) busy_n++;
    end
    chk("rstmid_line_idle", mism, 0);
    chk("rstmid_busy_idle", busy_n, 0);
    chk("rstmid_no_stale", rx_q.size() - base, 0);
    @(posedge clk); #1;
    base = rx_q.size();
    push_byte(8'hA5, 1'b0, stalls);
    tvalid = 1'b0;
    wait_idle("rstmid_a5");
    chk("rstmid_a5_count", rx_q.size() - base, 1);
    if (rx_q.size() - base == 1) chk("rstmid_a5", int'(rx_q[base]), 'hA5);

    // Random soak: 500 bytes per instance with random tlast and valid gaps
    for (int inst = 0; inst < 2; inst++) begin
      sel = inst[0];
      @(posedge clk); #1;
      expq.delete();
      base = rx_q.size();
      for (int n = 0; n < 500; n++) begin
        int gap;
        gap = $urandom_range(0, 3);
        if (gap > 0) begin
          tvalid = 1'b0;
          repeat (gap) @(posedge clk);
          #1;
        end
        d = 8'($urandom);
        l = ($urandom_range(0, 3) == 0);
        push_byte(d, l, stalls);
        expq.push_back(d);
        if (inst == 1 && l) expq.push_back(8'h0A);
      end
      tvalid = 1'b0;
      wait_idle("soak");
      chk($sformatf("soak%0d_count", inst), rx_q.size() - base, expq.size());
      mism = 0;
      for (int i = 0; i < expq.size() && base + i < rx_q.size(); i++) begin
        if (rx_q[base+i] !== expq[i]) begin
          if (mism < 4)
            $display("soak%0d byte %0d: got 0x%0h expected 0x%0h", inst, i, rx_q[base+i], expq[i]);
          mism++;
        end
      end
      chk($sformatf("soak%0d_byte_mism", inst), mism, 0);
    end

    chk("frame_errors", frame_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_uart_tx.md
# axis_uart_tx

Buffered AXI-Stream-to-UART transmitter that drains the 8-bit result stream produced by `corescorecore` onto a single serial TX pin. It sits directly downstream of the core's stream output, on the same board clock. It is a drop-in alternative to the current emitter path for boards whose clocks do not suit it. A small FIFO decouples core bursts from the slow line rate, and an optional newline is appended after every `tlast` byte.

## Interface
- `CLK_FREQ_HZ`, default 16_000_000: frequency of `i_clk`.
- `BAUD_RATE`, default 57600: line rate. Bit period `DIV = CLK_FREQ_HZ / BAUD_RATE` (integer truncation). `DIV` must be ≥ 2.
- `FIFO_DEPTH`, default 16: entries. Must be a power of two, ≥ 2.
- `APPEND_NL`, default 1: when 1, emit an extra 0x0A frame after each byte stored with `tlast` = 1.
- `i_clk` input, 1 bit: the single clock. All logic is on its rising edge.
- `i_rst_n` input, 1 bit: asynchronous, active-low reset.
- `i_tdata` input, 8 bits: stream byte.
- `i_tlast` input, 1 bit: marks the last byte of a message.
- `i_tvalid` input, 1 bit: stream valid.
- `o_tready` output, 1 bit: stream ready. Equals `i_rst_n && !fifo_full`.
- `o_uart_tx` output, 1 bit: serial line, idle high, registered.
- `o_busy` output, 1 bit: high while a frame is on the line or the FIFO is non-empty.

## Operation
- Reset (async, while `i_rst_n`=0):
  - FIFO is emptied. Pointers and count go to 0.
  - FSM goes to IDLE, baud counter to 0, bit index to 0, NL-pending flag to 0.
  - `o_uart_tx`=1, `o_busy`=0, `o_tready`=0.
  - Reset asserted mid-frame truncates the frame immediately. The line goes high, with no stop bit completion.
- FIFO: 9 bits wide (`{tlast, tdata}`).
  - Write on an edge with `i_tvalid && o_tready`.
  - Read (pop) by the FSM only. Count tracks write minus read each edge. Simultaneous write and read leaves count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Full when count == `FIFO_DEPTH`. A full FIFO drops no data because `o_tready` is low.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - If NL-pending, load shift register with 0x0A and clear NL-pending.
    - Otherwise, if the FIFO is non-empty, pop the head, load shift register, and set NL-pending = `APPEND_NL && tlast`.
    - In either case go to START, drive `o_uart_tx`=0, and clear the baud counter.
    - Otherwise stay in IDLE with `o_uart_tx`=1.
  - START: hold 0 for `DIV` cycles, then output bit 0 and go to DATA.
  - DATA: each bit is held `DIV` cycles, LSB first. After bit 7's period, drive 1 and go to STOP.
  - STOP: hold 1 for `DIV` cycles. At the final cycle, apply the IDLE selection rules in the same edge. A start bit therefore follows the stop bit with zero idle cycles when data or a newline is pending. Otherwise enter IDLE.
- Baud counter counts 0..DIV-1 and wraps on each bit boundary. Its width is clog2(DIV).
- A byte with `tlast`=0 never produces a newline. `APPEND_NL`=0 never produces a newline.

## Timing
- Acceptance edge E0 writes the FIFO. If the FSM is in IDLE, `o_uart_tx` falls at E1, giving a latency of 1 cycle from acceptance to start bit.
- `o_busy` rises at E0+1 cycle together with count ≥ 1. It falls on the edge where STOP completes with FIFO empty and NL-pending = 0.
- Each frame occupies exactly 10·`DIV` cycles: 1 start, 8 data, 1 stop.
- Back-to-back frames have no gap.
- Throughput is one byte per 10·`DIV` cycles, or one per 20·`DIV` cycles for `tlast` bytes when `APPEND_NL`=1.
- `o_tready` deasserts combinationally in the cycle the count reaches `FIFO_DEPTH`. It reasserts in the cycle after a pop.

## Test plan
- Single byte. Parameters `CLK_FREQ_HZ`=40, `BAUD_RATE`=10 (`DIV`=4), `APPEND_NL`=0.
  - Stimulus: send 0x55 with `tlast`=0.
  - Required: line goes low 1 cycle after acceptance; bits 1,0,1,0,1,0,1,0 each held 4 cycles; stop bit high for 4 cycles; `o_busy` high for exactly 40 cycles.
- Newline. Same parameters with `APPEND_NL`=1.
  - Stimulus: send 0x41 with `tlast`=1.
  - Required: frame 0x41, then frame 0x0A back-to-back; 80 busy cycles; no third frame.
- Backpressure. `FIFO_DEPTH`=4, `DIV`=4.
  - Stimulus: hold `i_tvalid`=1 with bytes 0x01..0x08.
  - Required: `o_tready` drops when 4 bytes are queued behind the active frame; all 8 bytes emerge in order with no loss or duplication; the receiver model decodes 0x01..0x08.
- Back-to-back. `DIV`=4.
  - Stimulus: push 3 bytes in consecutive cycles.
  - Required: 3 frames totalling 120 cycles; stop-to-start transitions have zero idle cycles.
- Reset mid-frame.
  - Stimulus: assert `i_rst_n`=0 during DATA bit 3 with 2 bytes queued.
  - Required: `o_uart_tx`=1, `o_busy`=0, `o_tready`=0 immediately, without waiting for a clock edge. After release, the line stays idle and no stale byte is emitted. A new byte 0xA5 then transmits correctly.
- Random soak.
  - Stimulus: 1000 random bytes with random `tlast` and random `i_tvalid` gaps.
  - Required: the UART receiver model output equals the input sequence, with 0x0A inserted after each `tlast` byte.
